// File: rtl/rv_fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch sequencer.
package rv_fetch_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:2] pc;
      logic        err;
   } fetch_entry_t;

   localparam int FETCH_DEPTH_DEFAULT = 2;

   // Counters must hold 0..DEPTH inclusive, hence one bit above the pointer width.
   function automatic int fetch_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int FETCH_CNT_W = fetch_cnt_w(FETCH_DEPTH_DEFAULT);

endpackage

// File: rtl/rv_fetch_fifo.sv
// Small synchronous FIFO with flush, no bypass: a push becomes visible the next cycle.
module rv_fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_flush,
   input  logic                            i_push,
   input  logic [WIDTH-1:0]                i_data,
   input  logic                            i_pop,
   output logic [WIDTH-1:0]                o_data,
   output logic                            o_vld,
   output logic [fetch_cnt_w(DEPTH)-1:0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = fetch_cnt_w(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             pop_ok;

   assign pop_ok  = i_pop & (count_q != '0);
   assign o_data  = mem_q[rd_ptr_q];
   assign o_vld   = (count_q != '0);
   assign o_count = count_q;

   // Pointer and occupancy update; flush discards everything including a same-cycle push.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (i_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(i_push) - CW'(pop_ok);
      end
   end

   // Storage write path.
   always_comb begin
      mem_d = mem_q;
      if (i_push && !i_flush) mem_d[wr_ptr_q] = i_data;
   end

   // Control state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage register; contents are only meaningful under o_vld so no reset.
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   // A push into a full FIFO means the upstream credit accounting is broken.
   always_ff @(posedge i_clk) begin
      if (!i_reset && !i_flush) assert (!(i_push && !pop_ok && (count_q == CW'(DEPTH))));
   end

endmodule

// File: rtl/rv_fetch_ctrl.sv
// Instruction-fetch sequencer: issues word reads under a credit limit, buffers
// in-order responses for decode, discards stale responses after a redirect and
// halts fetching after an access fault until decode redirects.
module rv_fetch_ctrl
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          DEPTH      = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pc_sel,
   input  logic [31:2] i_pc_target,
   input  logic        i_stall,
   output logic        o_bus_req,
   output logic [31:2] o_bus_addr,
   input  logic        i_bus_gnt,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_err,
   output logic        o_instr_vld,
   output logic [31:0] o_instr,
   output logic [31:2] o_instr_pc,
   output logic        o_instr_err,
   output logic        o_busy
);

   localparam int CW  = fetch_cnt_w(DEPTH);
   localparam int CWP = CW + 1;
   localparam logic [CW:0] DEPTH_LIM = CWP'(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:2]   req_pc_q, req_pc_d;
   logic [CW-1:0] disc_q, disc_d;

   fetch_entry_t  ififo_wdata, ififo_rdata;
   logic          ififo_push, ififo_vld;
   logic [CW-1:0] ififo_count;

   logic [31:2]   pcq_rdata;
   logic          pcq_vld;
   logic [CW-1:0] pcq_count;

   logic          pop, issue_ok, gnt_fire, ack_fire;
   logic [CW:0]   credit_sum;

   // The in-flight PC queue depth doubles as the outstanding-read count.
   assign pop        = ififo_vld & ~i_stall;
   assign credit_sum = {1'b0, ififo_count} + {1'b0, pcq_count} - CWP'(pop);
   assign issue_ok   = credit_sum < DEPTH_LIM;
   assign o_bus_req  = ~i_reset & (state_q == RUN) & issue_ok & ~i_pc_sel;
   assign o_bus_addr = req_pc_q;
   assign gnt_fire   = o_bus_req & i_bus_gnt;
   assign ack_fire   = i_bus_ack & pcq_vld;

   assign o_instr_vld = ififo_vld;
   assign o_instr     = ififo_vld ? ififo_rdata.instr : '0;
   assign o_instr_pc  = ififo_vld ? ififo_rdata.pc    : '0;
   assign o_instr_err = ififo_vld ? ififo_rdata.err   : 1'b0;
   assign o_busy      = (pcq_count != '0) | (disc_q != '0);

   // Next-state: redirect overrides grants, responses and fault handling.
   always_comb begin
      state_d     = state_q;
      req_pc_d    = req_pc_q;
      disc_d      = disc_q;
      ififo_push  = 1'b0;
      ififo_wdata = '{instr: i_bus_rdata, pc: pcq_rdata, err: i_bus_err};
      if (i_pc_sel) begin
         state_d  = RUN;
         req_pc_d = i_pc_target;
         disc_d   = pcq_count + CW'(gnt_fire) - CW'(ack_fire);
      end else begin
         if (gnt_fire) req_pc_d = req_pc_q + 30'd1;
         if (ack_fire) begin
            if (disc_q != '0) begin
               disc_d = disc_q - CW'(1);
            end else begin
               ififo_push = 1'b1;
               if (i_bus_err) state_d = HALT;
            end
         end
      end
   end

   // Control registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= RUN;
         req_pc_q <= RESET_ADDR[31:2];
         disc_q   <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
         disc_q   <= disc_d;
      end
   end

   rv_fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_instr_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (i_pc_sel),
      .i_push  (ififo_push),
      .i_data  (ififo_wdata),
      .i_pop   (pop),
      .o_data  (ififo_rdata),
      .o_vld   (ififo_vld),
      .o_count (ififo_count)
   );

   rv_fetch_fifo #(
      .WIDTH (30),
      .DEPTH (DEPTH)
   ) u_pc_queue (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (1'b0),
      .i_push  (gnt_fire),
      .i_data  (req_pc_q),
      .i_pop   (ack_fire),
      .o_data  (pcq_rdata),
      .o_vld   (pcq_vld),
      .o_count (pcq_count)
   );

endmodule
